if_id_skid: RTL and testbench

- Parametrised successor to the plain IF/ID pipeline register.
- Sits between fetch and decode and replaces the single hold-flag register with a valid/ready handshake.
- Holds up to two in-flight fetch packets (main + skid entry), so fetch and decode decouple without a combinational ready path.
- Supports synchronous flush (branch/jump/trap redirect).
- Presents a NOP bubble whenever it holds no valid packet.

---
 rtl/if_id_skid_pkg.sv | 14 +
 rtl/if_id_skid_entry.sv | 42 ++++
 rtl/if_id_skid.sv | 127 ++++++++++++
 tb/tb_if_id_skid.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/if_id_skid_pkg.sv
// Shared definitions for the IF/ID skid stage.
//   state_e : occupancy states; the encoding doubles as the occupancy count.
//   InstNop : canonical NOP (addi x0, x0, 0) shown whenever no packet is held.
package if_id_skid_pkg;

    localparam logic [31:0] InstNop = 32'h0000_0013;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

endpackage

// File: rtl/if_id_skid_entry.sv
// Load-enabled storage slot for one fetch packet.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset, loads ResetVal
//   clr_i  : synchronous clear to ResetVal (wins over load_i)
//   load_i : capture d_i
//   d_i    : packet in
//   q_o    : packet held
module pipe_entry #(
    parameter int unsigned       Width    = 64,
    parameter logic [Width-1:0]  ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = ResetVal;
        end else if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= ResetVal;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with a two-entry valid/ready skid buffer.
// Ports:
//   clk, rst                 : clock and asynchronous active-high reset
//   in_valid_i / in_ready_o  : fetch handshake; in_ready_o is purely registered
//   inst_i, inst_addr_i      : fetched packet
//   flush_i                  : drop everything held plus the current input
//   out_valid_o / out_ready_i: decode handshake
//   inst_o, inst_addr_o      : packet to decode (NOP/0 when empty)
//   count_o                  : occupancy 0..2
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(InstNop)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [1:0]        count_o
);

    localparam int unsigned           PktW   = INST_W + ADDR_W;
    localparam logic [PktW-1:0]       PktNop = {NOP_INST, {ADDR_W{1'b0}}};

    state_e state_d, state_q;

    logic            in_fire, out_fire;
    logic            main_load, main_clr, main_sel_skid;
    logic            skid_load, skid_clr;
    logic [PktW-1:0] in_pkt, main_d, main_q, skid_q;

    assign in_ready_o  = (state_q != StTwo);
    assign out_valid_o = (state_q != StEmpty);
    assign in_fire     = in_valid_i & in_ready_o & ~flush_i;
    assign out_fire    = out_valid_o & out_ready_i;
    assign in_pkt      = {inst_i, inst_addr_i};
    assign main_d      = main_sel_skid ? skid_q : in_pkt;

    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (flush_i) begin
            state_d  = StEmpty;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = StTwo;
                    end else if (out_fire) begin
                        // Clear so the bubble reads NOP/0 from a register.
                        main_clr = 1'b1;
                        state_d  = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        state_d       = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_entry #(
        .Width   (PktW),
        .ResetVal(PktNop)
    ) u_main (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (main_clr),
        .load_i(main_load),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_entry #(
        .Width   (PktW),
        .ResetVal(PktNop)
    ) u_skid (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (skid_clr),
        .load_i(skid_load),
        .d_i   (in_pkt),
        .q_o   (skid_q)
    );

    assign inst_o      = main_q[PktW-1:ADDR_W];
    assign inst_addr_o = main_q[ADDR_W-1:0];
    assign count_o     = state_q;

endmodule

// File: tb/tb_if_id_skid.sv
module tb_if_id_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [1:0]  count_o;

    int errors = 0;
    int checks = 0;

    // Model: FIFO of {inst, addr} in acceptance order.
    logic [63:0] q[$];

    // Stability tracking across cycles.
    logic        prev_hold = 1'b0;
    logic [63:0] prev_pkt;

    if_id_skid u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .inst_i     (inst_i),
        .inst_addr_i(inst_addr_i),
        .flush_i    (flush_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .inst_o     (inst_o),
        .inst_addr_o(inst_addr_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int n;
        n = q.size();
        chk("out_valid", 64'(out_valid_o), 64'(n > 0));
        chk("in_ready", 64'(in_ready_o), 64'(n < 2));
        chk("count", 64'(count_o), 64'(n));
        chk("inst", 64'(inst_o), (n > 0) ? 64'(q[0][63:32]) : 64'h13);
        chk("addr", 64'(inst_addr_o), (n > 0) ? 64'(q[0][31:0]) : 64'h0);
        chk("count_le2", 64'(count_o <= 2'd2), 64'd1);
        chk("notready_full", 64'(in_ready_o || count_o == 2'd2), 64'd1);
        if (prev_hold) chk("stable", {inst_o, inst_addr_o}, prev_pkt);
    endtask

    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                       input logic rdy, input logic fl);
        int  n;
        logic inf, outf;
        @(negedge clk);
        model_check();
        in_valid_i  = v;
        inst_i      = inst;
        inst_addr_i = addr;
        out_ready_i = rdy;
        flush_i     = fl;
        n    = q.size();
        inf  = v && (n < 2) && !fl;
        outf = (n > 0) && rdy;
        prev_hold = (n > 0) && !rdy && !fl;
        prev_pkt  = (n > 0) ? q[0] : 64'h0;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back({inst, addr});
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid_i = 1'b0; inst_i = '0; inst_addr_i = '0;
        flush_i = 1'b0; out_ready_i = 1'b0;
        #12;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_inst", 64'(inst_o), 64'h13);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Streaming, one packet per cycle.
        cyc(1'b1, 32'hA000_0001, 32'h0, 1'b1, 1'b0);
        chk("s1_inst", 64'(inst_o), 64'hA000_0001);
        chk("s1_cnt", 64'(count_o), 64'd1);
        cyc(1'b1, 32'hA000_0002, 32'h4, 1'b1, 1'b0);
        chk("s2_inst", 64'(inst_o), 64'hA000_0002);
        chk("s2_addr", 64'(inst_addr_o), 64'h4);
        cyc(1'b1, 32'hA000_0003, 32'h8, 1'b1, 1'b0);
        cyc(1'b1, 32'hA000_0004, 32'hC, 1'b1, 1'b0);
        chk("s4_inst", 64'(inst_o), 64'hA000_0004);
        chk("s4_cnt", 64'(count_o), 64'd1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_inst", 64'(inst_o), 64'h13);

        // Backpressure into the skid entry.
        cyc(1'b1, 32'h11, 32'h100, 1'b1, 1'b0);
        cyc(1'b1, 32'h22, 32'h104, 1'b0, 1'b0);
        chk("bp_cnt", 64'(count_o), 64'd2);
        chk("bp_ready", 64'(in_ready_o), 64'd0);
        chk("bp_inst", 64'(inst_o), 64'h11);
        chk("bp_addr", 64'(inst_addr_o), 64'h100);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("rel_inst", 64'(inst_o), 64'h22);
        chk("rel_addr", 64'(inst_addr_o), 64'h104);
        chk("rel_ready", 64'(in_ready_o), 64'd1);

        // Flush from the full state with a live input.
        cyc(1'b1, 32'h44, 32'h108, 1'b0, 1'b0);
        chk("full_cnt", 64'(count_o), 64'd2);
        cyc(1'b1, 32'h33, 32'h10C, 1'b0, 1'b1);
        chk("fl2_cnt", 64'(count_o), 64'd0);
        chk("fl2_valid", 64'(out_valid_o), 64'd0);
        chk("fl2_inst", 64'(inst_o), 64'h13);
        chk("fl2_addr", 64'(inst_addr_o), 64'h0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("no33", 64'(out_valid_o), 64'd0);

        // Flush with a simultaneous consume in ONE.
        cyc(1'b1, 32'h55, 32'h200, 1'b1, 1'b0);
        chk("one_inst", 64'(inst_o), 64'h55);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("flc_cnt", 64'(count_o), 64'd0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flc_nodup", 64'(out_valid_o), 64'd0);

        // Asynchronous reset mid-cycle while full and with input valid.
        cyc(1'b1, 32'h66, 32'h300, 1'b0, 1'b0);
        cyc(1'b1, 32'h77, 32'h304, 1'b0, 1'b0);
        chk("pre_rst_cnt", 64'(count_o), 64'd2);
        #2;
        rst = 1'b1;
        in_valid_i = 1'b1;
        #1;
        chk("mrst_valid", 64'(out_valid_o), 64'd0);
        chk("mrst_inst", 64'(inst_o), 64'h13);
        chk("mrst_addr", 64'(inst_addr_o), 64'h0);
        chk("mrst_ready", 64'(in_ready_o), 64'd1);
        chk("mrst_cnt", 64'(count_o), 64'd0);
        q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        in_valid_i = 1'b0;

        // Random valid/ready/flush against the FIFO model.
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
        end
        @(negedge clk);
        model_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
